dec_div_ctl: RTL and testbench

- Decode-side initiator for the EXU divider.
- Issues a divide request into the EXU (div_p / dec_i0_div_d), tracks the in-flight divide and its destination register, captures the result on exu_div_finish, and arbitrates it onto a GPR writeback port.
- Sits in DEC between the I0 decoder and the GPR writeback mux.
- Provides busy/scoreboard outputs to stall decode and catches divider protocol errors.

---
 rtl/swerv_types.sv | 26 ++
 rtl/dec_div_ctl.sv | 117 +++++++++++
 tb/tb_dec_div_ctl.sv | 283 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/swerv_types.sv
//------------------------------------------------------------------------------
// swerv_types : shared types and constants for the DEC divide controller
// Revision    : 1.0
//------------------------------------------------------------------------------
`default_nettype none

package swerv_types;

    localparam int DIV_TIMEOUT_DEF = 40;
    localparam int DIV_XLEN_DEF    = 32;
    localparam int DIV_RW_DEF      = 5;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        WB   = 2'd2
    } div_ctl_state_e;

    typedef struct packed {
        logic [DIV_RW_DEF-1:0]   rd;
        logic [DIV_XLEN_DEF-1:0] data;
    } div_wb_pkt_t;

endpackage

`default_nettype wire

// File: rtl/dec_div_ctl.sv
//------------------------------------------------------------------------------
// dec_div_ctl : decode-side divide initiator, in-flight tracker and GPR
//               writeback requester for the EXU divider
// Revision    : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module dec_div_ctl
    import swerv_types::*;
#(
    parameter int XLEN        = 32,
    parameter int RW          = 5,
    parameter int DIV_TIMEOUT = DIV_TIMEOUT_DEF
) (
    input  logic            clk,
    input  logic            rst_l,
    input  logic            dec_div_valid_d,
    input  logic            dec_div_unsign_d,
    input  logic            dec_div_rem_d,
    input  logic [RW-1:0]   dec_div_rd_d,
    input  logic            lsu_freeze_dc3,
    input  logic            dec_tlu_flush_lower_wb,
    input  logic            exu_div_finish,
    input  logic [XLEN-1:0] exu_div_result,
    output logic            div_p_valid,
    output logic            div_p_unsign,
    output logic            div_p_rem,
    output logic            dec_i0_div_d,
    output logic            div_busy,
    output logic            div_rd_busy,
    output logic [RW-1:0]   div_rd,
    output logic            wb_div_req,
    output logic [RW-1:0]   wb_div_rd,
    output logic [XLEN-1:0] wb_div_data,
    input  logic            wb_div_gnt,
    output logic [1:0]      div_err
);

    localparam int             WDW     = $clog2(DIV_TIMEOUT);
    localparam logic [WDW-1:0] WD_LAST = WDW'(DIV_TIMEOUT - 1);
    localparam logic [WDW-1:0] WD_ONE  = WDW'(1);

    div_ctl_state_e  r_state;
    logic [WDW-1:0]  r_wdog;
    logic [RW-1:0]   r_div_rd;
    logic [RW-1:0]   r_wb_rd;
    logic [XLEN-1:0] r_wb_data;
    logic            r_wb_req;
    logic [1:0]      r_err;
    logic            w_issue;

    // The EXU samples the request alongside the D-stage operands, so no flop here.
    assign w_issue      = dec_div_valid_d & (r_state == IDLE) & ~lsu_freeze_dc3
                        & ~dec_tlu_flush_lower_wb;
    assign div_p_valid  = w_issue;
    assign div_p_unsign = w_issue & dec_div_unsign_d;
    assign div_p_rem    = w_issue & dec_div_rem_d;
    assign dec_i0_div_d = w_issue;

    assign div_busy    = (r_state != IDLE);
    assign div_rd_busy = (r_state == RUN) | (r_state == WB);
    assign div_rd      = r_div_rd;
    assign wb_div_req  = r_wb_req;
    assign wb_div_rd   = r_wb_rd;
    assign wb_div_data = r_wb_data;
    assign div_err     = r_err;

    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            r_state   <= IDLE;
            r_wdog    <= '0;
            r_div_rd  <= '0;
            r_wb_rd   <= '0;
            r_wb_data <= '0;
            r_wb_req  <= 1'b0;
            r_err     <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (exu_div_finish) r_err[1] <= 1'b1;
                    if (w_issue) begin
                        r_div_rd <= dec_div_rd_d;
                        r_wdog   <= '0;
                        r_state  <= RUN;
                    end
                end
                RUN: begin
                    if (r_wdog != '1) r_wdog <= r_wdog + WD_ONE;
                    // A flush kills the divide even if its result arrives this cycle.
                    if (dec_tlu_flush_lower_wb) begin
                        r_state <= IDLE;
                    end else if (exu_div_finish) begin
                        r_wb_data <= exu_div_result;
                        r_wb_rd   <= r_div_rd;
                        r_wb_req  <= 1'b1;
                        r_state   <= WB;
                    end else if (r_wdog == WD_LAST) begin
                        r_err[0] <= 1'b1;
                        r_state  <= IDLE;
                    end
                end
                WB: begin
                    // The result is architecturally complete here; flush is ignored.
                    if (exu_div_finish) r_err[1] <= 1'b1;
                    if (wb_div_gnt) begin
                        r_wb_req <= 1'b0;
                        r_state  <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_dec_div_ctl.sv
// tb_dec_div_ctl : directed scenarios plus randomized traffic, every cycle checked
// against a transaction-level model of the divide controller.
`default_nettype none

module tb_dec_div_ctl;

    localparam int XLEN = 32;
    localparam int RW   = 5;
    localparam int TMO  = 40;

    logic            clk = 1'b0;
    logic            rst_l = 1'b0;
    logic            dec_div_valid_d = 1'b0;
    logic            dec_div_unsign_d = 1'b0;
    logic            dec_div_rem_d = 1'b0;
    logic [RW-1:0]   dec_div_rd_d = '0;
    logic            lsu_freeze_dc3 = 1'b0;
    logic            dec_tlu_flush_lower_wb = 1'b0;
    logic            exu_div_finish = 1'b0;
    logic [XLEN-1:0] exu_div_result = '0;
    logic            wb_div_gnt = 1'b0;
    logic            div_p_valid, div_p_unsign, div_p_rem, dec_i0_div_d;
    logic            div_busy, div_rd_busy, wb_div_req;
    logic [RW-1:0]   div_rd, wb_div_rd;
    logic [XLEN-1:0] wb_div_data;
    logic [1:0]      div_err;

    dec_div_ctl #(.XLEN(XLEN), .RW(RW), .DIV_TIMEOUT(TMO)) dut (
        .clk(clk), .rst_l(rst_l),
        .dec_div_valid_d(dec_div_valid_d), .dec_div_unsign_d(dec_div_unsign_d),
        .dec_div_rem_d(dec_div_rem_d), .dec_div_rd_d(dec_div_rd_d),
        .lsu_freeze_dc3(lsu_freeze_dc3), .dec_tlu_flush_lower_wb(dec_tlu_flush_lower_wb),
        .exu_div_finish(exu_div_finish), .exu_div_result(exu_div_result),
        .div_p_valid(div_p_valid), .div_p_unsign(div_p_unsign), .div_p_rem(div_p_rem),
        .dec_i0_div_d(dec_i0_div_d), .div_busy(div_busy), .div_rd_busy(div_rd_busy),
        .div_rd(div_rd), .wb_div_req(wb_div_req), .wb_div_rd(wb_div_rd),
        .wb_div_data(wb_div_data), .wb_div_gnt(wb_div_gnt), .div_err(div_err)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h required 0x%0h at t=%0t", name, act, exp, $time);
        end
    endtask

    // Transaction-level model: one divide may be waiting on the EXU, or one
    // finished result may be waiting for the writeback port.
    bit              m_waiting = 0;
    bit              m_result = 0;
    int              m_age = 0;
    logic [RW-1:0]   m_rd = '0;
    logic [RW-1:0]   m_wb_rd = '0;
    logic [XLEN-1:0] m_wb_data = '0;
    logic [1:0]      m_err = '0;

    task automatic model_reset();
        m_waiting = 0; m_result = 0; m_age = 0;
        m_rd = '0; m_wb_rd = '0; m_wb_data = '0; m_err = '0;
    endtask

    always @(negedge clk) begin
        bit free, pv;
        if (!rst_l) model_reset();
        free = !m_waiting && !m_result;
        pv   = dec_div_valid_d && free && !lsu_freeze_dc3 && !dec_tlu_flush_lower_wb;
        chk("div_p_valid", div_p_valid, pv);
        chk("div_p_unsign", div_p_unsign, pv && dec_div_unsign_d);
        chk("div_p_rem", div_p_rem, pv && dec_div_rem_d);
        chk("dec_i0_div_d", dec_i0_div_d, pv);
        chk("div_busy", div_busy, !free);
        chk("div_rd_busy", div_rd_busy, !free);
        chk("div_rd", div_rd, m_rd);
        chk("wb_div_req", wb_div_req, m_result);
        chk("wb_div_rd", wb_div_rd, m_wb_rd);
        chk("wb_div_data", wb_div_data, m_wb_data);
        chk("div_err", div_err, m_err);
        if (rst_l) begin
            if (m_result) begin
                if (exu_div_finish) m_err[1] = 1'b1;
                if (wb_div_gnt) m_result = 0;
            end else if (m_waiting) begin
                m_age = m_age + 1;
                if (dec_tlu_flush_lower_wb) m_waiting = 0;
                else if (exu_div_finish) begin
                    m_waiting = 0; m_result = 1;
                    m_wb_rd = m_rd; m_wb_data = exu_div_result;
                end else if (m_age == TMO) begin
                    m_waiting = 0; m_err[0] = 1'b1;
                end
            end else begin
                if (exu_div_finish) m_err[1] = 1'b1;
                if (pv) begin m_waiting = 1; m_age = 0; m_rd = dec_div_rd_d; end
            end
        end
    end

    // Simple EXU stand-in: finishes exu_lat cycles after an accepted request.
    int              exu_cnt = -1;
    int              exu_lat = 1;
    bit              spurious = 0;
    logic [XLEN-1:0] next_res = '0;
    logic [XLEN-1:0] pend_res = '0;

    function automatic logic [XLEN-1:0] ref_div(input logic [XLEN-1:0] a, input logic [XLEN-1:0] b,
                                                input bit uns, input bit rem);
        if (b == 0) return rem ? a : '1;
        if (uns) return rem ? a % b : a / b;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return rem ? '0 : a;
        return rem ? $unsigned($signed(a) % $signed(b)) : $unsigned($signed(a) / $signed(b));
    endfunction

    task automatic set_op(input bit v, input bit uns, input bit rem, input logic [RW-1:0] rd,
                          input logic [XLEN-1:0] a, input logic [XLEN-1:0] b, input int lat);
        dec_div_valid_d = v; dec_div_unsign_d = uns; dec_div_rem_d = rem; dec_div_rd_d = rd;
        next_res = ref_div(a, b, uns, rem);
        exu_lat = lat;
    endtask

    task automatic run_cycle(output bit issued);
        exu_div_finish = (exu_cnt == 0) || spurious;
        exu_div_result = (exu_cnt == 0) ? pend_res : XLEN'($urandom);
        #2;
        issued = div_p_valid;
        @(posedge clk);
        if (exu_cnt == 0) exu_cnt = -1;
        else if (exu_cnt > 0) exu_cnt--;
        if (dec_tlu_flush_lower_wb || !rst_l) exu_cnt = -1;
        if (issued && rst_l) begin exu_cnt = exu_lat - 1; pend_res = next_res; end
        spurious = 0;
        #1;
    endtask

    initial begin
        bit iss, got;
        int cnt;
        repeat (3) run_cycle(iss);
        chk("reset_busy", div_busy, 0);
        chk("reset_req", wb_div_req, 0);
        chk("reset_err", div_err, 0);
        chk("reset_data", wb_div_data, 0);
        rst_l = 1'b1;
        run_cycle(iss);

        // Unsigned 0x100 / 2 to x5, grant always available
        wb_div_gnt = 1'b1;
        set_op(1, 1, 0, 5'd5, 32'h100, 32'h2, 3);
        run_cycle(iss);
        chk("t1_issue", iss, 1);
        dec_div_valid_d = 1'b0;
        chk("t1_busy", div_busy, 1);
        cnt = 0;
        for (int i = 0; i < 10; i++) begin
            run_cycle(iss);
            if (wb_div_req) begin
                cnt++;
                chk("t1_wb_rd", wb_div_rd, 5);
                chk("t1_wb_data", wb_div_data, 32'h80);
            end
        end
        chk("t1_req_cycles", cnt, 1);
        chk("t1_idle", div_busy, 0);

        // Same op, grant held off for three cycles; issue attempts blocked in WB
        wb_div_gnt = 1'b0;
        set_op(1, 1, 0, 5'd5, 32'h100, 32'h2, 6);
        run_cycle(iss);
        dec_div_valid_d = 1'b0;
        got = 0;
        for (int i = 0; i < 20 && !got; i++) begin
            run_cycle(iss);
            got = wb_div_req;
        end
        chk("t2_req_seen", got, 1);
        dec_div_valid_d = 1'b1;
        for (int i = 0; i < 3; i++) begin
            run_cycle(iss);
            chk("t2_blocked_issue", iss, 0);
            chk("t2_req_held", wb_div_req, 1);
            chk("t2_data_held", wb_div_data, 32'h80);
        end
        wb_div_gnt = 1'b1;
        run_cycle(iss);
        chk("t2_gnt_cycle_issue", iss, 0);
        chk("t2_req_drop", wb_div_req, 0);
        dec_div_valid_d = 1'b0;
        run_cycle(iss);

        // Signed -7 rem 2, flushed five cycles after issue
        set_op(1, 0, 1, 5'd9, 32'hFFFF_FFF9, 32'h2, 20);
        run_cycle(iss);
        dec_div_valid_d = 1'b0;
        repeat (4) run_cycle(iss);
        dec_tlu_flush_lower_wb = 1'b1;
        run_cycle(iss);
        dec_tlu_flush_lower_wb = 1'b0;
        chk("t3_flush_idle", div_busy, 0);
        got = 0;
        for (int i = 0; i < 25; i++) begin
            run_cycle(iss);
            if (wb_div_req) got = 1;
        end
        chk("t3_no_req", got, 0);
        chk("t3_err", div_err, 0);

        // Finish coinciding with flush
        set_op(1, 1, 1, 5'd3, 32'd17, 32'd5, 4);
        run_cycle(iss);
        dec_div_valid_d = 1'b0;
        repeat (3) run_cycle(iss);
        dec_tlu_flush_lower_wb = 1'b1;
        run_cycle(iss);
        dec_tlu_flush_lower_wb = 1'b0;
        chk("t4_idle", div_busy, 0);
        chk("t4_no_req", wb_div_req, 0);
        chk("t4_err", div_err, 0);

        // Freeze blocks issue; then a divide that never finishes times out
        set_op(1, 1, 0, 5'd12, 32'd9, 32'd3, 1000);
        lsu_freeze_dc3 = 1'b1;
        run_cycle(iss);
        chk("t5_frozen_issue", iss, 0);
        chk("t5_frozen_busy", div_busy, 0);
        lsu_freeze_dc3 = 1'b0;
        run_cycle(iss);
        chk("t5_issue", iss, 1);
        dec_div_valid_d = 1'b0;
        repeat (TMO - 1) run_cycle(iss);
        chk("t5_still_busy", div_busy, 1);
        chk("t5_no_err_yet", div_err, 0);
        run_cycle(iss);
        chk("t5_timeout_idle", div_busy, 0);
        chk("t5_timeout_err", div_err, 2'b01);
        chk("t5_no_req", wb_div_req, 0);
        exu_cnt = -1;
        spurious = 1;
        run_cycle(iss);
        chk("t5_late_finish_err", div_err, 2'b11);

        // Reset in the middle of a running divide
        set_op(1, 0, 0, 5'd7, 32'd100, 32'd7, 1000);
        run_cycle(iss);
        dec_div_valid_d = 1'b0;
        repeat (3) run_cycle(iss);
        rst_l = 1'b0;
        #1;
        chk("t6_busy", div_busy, 0);
        chk("t6_rd_busy", div_rd_busy, 0);
        chk("t6_div_rd", div_rd, 0);
        chk("t6_req", wb_div_req, 0);
        chk("t6_err", div_err, 0);
        run_cycle(iss);
        rst_l = 1'b1;
        run_cycle(iss);

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            logic [XLEN-1:0] a, b;
            a = XLEN'($urandom);
            b = ($urandom_range(0, 3) == 0) ? XLEN'($urandom_range(0, 3)) : XLEN'($urandom);
            set_op(bit'($urandom_range(0, 1)), bit'($urandom_range(0, 1)), bit'($urandom_range(0, 1)),
                   RW'($urandom), a, b, $urandom_range(1, 45));
            rst_l = ($urandom_range(0, 399) != 0);
            lsu_freeze_dc3 = ($urandom_range(0, 7) == 0);
            dec_tlu_flush_lower_wb = ($urandom_range(0, 19) == 0);
            wb_div_gnt = bit'($urandom_range(0, 1));
            spurious = ($urandom_range(0, 99) == 0);
            run_cycle(iss);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
